dmem_arbiter: RTL and testbench

//  Shares the single data_memory port between two requesters: port A (core MEM-stage access, issued

---
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter_if                                                            |
// | Requester (A/B) and data_memory signal bundle for dmem_arbiter.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [3:0]        a_byteena;
  logic              a_grant;
  logic              a_stall;
  logic              a_rvalid;

  logic              b_req;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [3:0]        b_byteena;
  logic              b_grant;
  logic              b_rvalid;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic [3:0]        mem_byteena;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_byteena,
    output a_grant, a_stall, a_rvalid,
    input  b_req, b_we, b_lock, b_addr, b_wdata, b_byteena,
    output b_grant, b_rvalid,
    output rdata,
    output mem_address, mem_data, mem_byteena, mem_wren,
    input  mem_q
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_byteena,
    input  a_grant, a_stall, a_rvalid,
    output b_req, b_we, b_lock, b_addr, b_wdata, b_byteena,
    input  b_grant, b_rvalid,
    input  rdata,
    input  mem_address, mem_data, mem_byteena, mem_wren,
    output mem_q
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter                                                               |
// | Shares data_memory between core port A (priority) and DMA port B with      |
// | starvation guard and B burst lock. DMEM_ARB_PERF_EN adds perf counters.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  wire logic    clock,
  input  wire logic    reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]  perf_a_stall_cnt,
  output logic [31:0]  perf_b_wait_cnt
`endif
);

  localparam logic [3:0] c_max_wait  = 4'(MAX_WAIT);
  localparam logic [3:0] c_burst_max = 4'(BURST_MAX);

  typedef enum logic [0:0] {
    A_OWN   = 1'b0,
    B_BURST = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_nxt;
  logic [3:0] r_burst_cnt;
  logic [3:0] w_burst_nxt;
  logic       r_a_rvalid;
  logic       r_b_rvalid;
  logic       w_rule_burst;
  logic       w_a_grant;
  logic       w_b_grant;
  logic       w_b_denied;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= A_OWN;
      r_wait_cnt  <= 4'd0;
      r_burst_cnt <= 4'd0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_a_rvalid  <= w_a_grant & ~bus.a_we;
      r_b_rvalid  <= w_b_grant & ~bus.b_we;
    end
  end

  // Grants are forced low while reset is held so nothing reaches the memory.
  always_comb begin
    w_rule_burst = (r_state == B_BURST) && bus.b_req && bus.b_lock &&
                   (r_burst_cnt < c_burst_max);
    w_a_grant    = 1'b0;
    w_b_grant    = 1'b0;
    if (reset) begin
      if (w_rule_burst)
        w_b_grant = 1'b1;
      else if (bus.a_req && (r_wait_cnt < c_max_wait))
        w_a_grant = 1'b1;
      else if (bus.b_req)
        w_b_grant = 1'b1;
      else if (bus.a_req)
        w_a_grant = 1'b1;
    end
    w_b_denied = bus.b_req & ~w_b_grant;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      A_OWN: begin
        if (w_b_grant && bus.b_lock) begin
          w_state_nxt = B_BURST;
          w_burst_nxt = 4'd1;
        end
      end
      B_BURST: begin
        if (w_rule_burst) begin
          w_burst_nxt = r_burst_cnt + 4'd1;
        end else begin
          w_state_nxt = A_OWN;
          w_burst_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = A_OWN;
        w_burst_nxt = 4'd0;
      end
    endcase

    w_wait_nxt = r_wait_cnt;
    if (!w_b_denied)
      w_wait_nxt = 4'd0;
    else if (r_wait_cnt < c_max_wait)
      w_wait_nxt = r_wait_cnt + 4'd1;
  end

  assign bus.a_grant     = w_a_grant;
  assign bus.b_grant     = w_b_grant;
  assign bus.a_stall     = bus.a_req & ~w_a_grant & reset;
  assign bus.a_rvalid    = r_a_rvalid;
  assign bus.b_rvalid    = r_b_rvalid;
  assign bus.rdata       = bus.mem_q;

  // Idle cycles keep the A inputs on the address bus.
  assign bus.mem_address = w_b_grant ? bus.b_addr    : bus.a_addr;
  assign bus.mem_data    = w_b_grant ? bus.b_wdata   : bus.a_wdata;
  assign bus.mem_byteena = w_b_grant ? bus.b_byteena : bus.a_byteena;
  assign bus.mem_wren    = (w_a_grant & bus.a_we) | (w_b_grant & bus.b_we);

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_a_stall_cnt <= 32'd0;
      perf_b_wait_cnt  <= 32'd0;
    end else begin
      if (bus.a_stall)
        perf_a_stall_cnt <= perf_a_stall_cnt + 32'd1;
      if (w_b_denied)
        perf_b_wait_cnt  <= perf_b_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter                                                            |
// | Directed self-checking bench for dmem_arbiter with a data_memory model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_a_stall_cnt;
  logic [31:0] perf_b_wait_cnt;
`endif

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (4),
    .BURST_MAX(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_a_stall_cnt(perf_a_stall_cnt),
    .perf_b_wait_cnt (perf_b_wait_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-input memory; unwritten words read back as {C0FFE, address}.
  logic [31:0] mem     [4096];
  bit          written [4096];
  always @(posedge clock) begin
    if (written[bus.mem_address])
      bus.mem_q <= mem[bus.mem_address];
    else
      bus.mem_q <= {20'hC0FFE, bus.mem_address};
    if (bus.mem_wren) begin
      written[bus.mem_address] <= 1'b1;
      for (int k = 0; k < 4; k++)
        if (bus.mem_byteena[k])
          mem[bus.mem_address][8*k +: 8] <= bus.mem_data[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.a_req     = 1'b0;
    bus.a_we      = 1'b0;
    bus.a_addr    = '0;
    bus.a_wdata   = '0;
    bus.a_byteena = 4'hF;
    bus.b_req     = 1'b0;
    bus.b_we      = 1'b0;
    bus.b_lock    = 1'b0;
    bus.b_addr    = '0;
    bus.b_wdata   = '0;
    bus.b_byteena = 4'hF;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    reset = 1'b0;
    // Requests held during reset must not produce grants, stalls or writes.
    bus.a_req = 1'b1;
    bus.a_we  = 1'b1;
    tick();
    tick();
    chk("rst_a_grant",  32'(bus.a_grant),  32'(0));
    chk("rst_a_stall",  32'(bus.a_stall),  32'(0));
    chk("rst_mem_wren", 32'(bus.mem_wren), 32'(0));
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'(0));
    chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'(0));
    idle();
    reset = 1'b1;
    tick();

    // A-only read of 0x010
    bus.a_req  = 1'b1;
    bus.a_addr = 12'h010;
    #1;
    chk("t1_a_grant",  32'(bus.a_grant),     32'(1));
    chk("t1_a_stall",  32'(bus.a_stall),     32'(0));
    chk("t1_mem_wren", 32'(bus.mem_wren),    32'(0));
    chk("t1_mem_addr", 32'(bus.mem_address), 32'h010);
    tick();
    idle();
    #1;
    chk("t1_a_rvalid", 32'(bus.a_rvalid), 32'(1));
    chk("t1_b_rvalid", 32'(bus.b_rvalid), 32'(0));
    chk("t1_rdata",    bus.rdata,         32'hC0FFE010);
    chk("t1_idle_wren", 32'(bus.mem_wren), 32'(0));

    // Fresh reset so the perf counters start from zero, then contend.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    bus.a_addr = 12'h100;
    bus.b_addr = 12'h200;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t2_a_grant", 32'(bus.a_grant), 32'((i % 5) != 4));
      chk("t2_b_grant", 32'(bus.b_grant), 32'((i % 5) == 4));
      chk("t2_a_stall", 32'(bus.a_stall), 32'((i % 5) == 4));
      chk("t2_mem_addr", 32'(bus.mem_address), ((i % 5) == 4) ? 32'h200 : 32'h100);
      chk("t2_b_rvalid", 32'(bus.b_rvalid), 32'((i % 5) == 0 && i > 0));
      tick();
    end
`ifdef DMEM_ARB_PERF_EN
    chk("t6_perf_a_stall", perf_a_stall_cnt, 32'd2);
    chk("t6_perf_b_wait",  perf_b_wait_cnt,  32'd8);
`endif
    idle();
    tick();

    // Locked burst: starvation guard releases B, 8 locked grants, A back, guard restarts.
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    bus.b_lock = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      chk("t3_b_grant", 32'(bus.b_grant), 32'((i >= 4 && i <= 11) || i == 16));
      chk("t3_a_grant", 32'(bus.a_grant), 32'(!((i >= 4 && i <= 11) || i == 16)));
      tick();
    end

    // Reset in the middle of a new burst: must drop back to A_OWN.
    bus.b_we = 1'b1;
    #1;
    chk("t5_burst_b_grant", 32'(bus.b_grant),  32'(1));
    chk("t5_burst_wren",    32'(bus.mem_wren), 32'(1));
    reset = 1'b0;
    #1;
    chk("t5_rst_b_grant", 32'(bus.b_grant),  32'(0));
    chk("t5_rst_a_grant", 32'(bus.a_grant),  32'(0));
    chk("t5_rst_a_stall", 32'(bus.a_stall),  32'(0));
    chk("t5_rst_wren",    32'(bus.mem_wren), 32'(0));
    tick();
    reset = 1'b1;
    #1;
    chk("t5_post_a_grant", 32'(bus.a_grant), 32'(1));
    chk("t5_post_b_grant", 32'(bus.b_grant), 32'(0));
    idle();
    tick();

    // A read granted, reset lands before the capturing edge: read is dropped.
    bus.a_req  = 1'b1;
    bus.a_addr = 12'h010;
    #1;
    chk("t5_rd_a_grant", 32'(bus.a_grant), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rd_grant_low", 32'(bus.a_grant), 32'(0));
    chk("t5_rd_stall_low", 32'(bus.a_stall), 32'(0));
    tick();
    chk("t5_rd_rvalid", 32'(bus.a_rvalid), 32'(0));
    idle();
    tick();
    reset = 1'b1;
    tick();

    // B write then A read back through the shared memory.
    bus.b_req     = 1'b1;
    bus.b_we      = 1'b1;
    bus.b_addr    = 12'h020;
    bus.b_wdata   = 32'hDEADBEEF;
    bus.b_byteena = 4'hF;
    #1;
    chk("t4_b_grant",   32'(bus.b_grant),     32'(1));
    chk("t4_wren",      32'(bus.mem_wren),    32'(1));
    chk("t4_mem_addr",  32'(bus.mem_address), 32'h020);
    chk("t4_mem_data",  bus.mem_data,         32'hDEADBEEF);
    chk("t4_mem_be",    32'(bus.mem_byteena), 32'hF);
    tick();
    idle();
    chk("t4_b_rvalid_wr", 32'(bus.b_rvalid), 32'(0));
    bus.a_req  = 1'b1;
    bus.a_addr = 12'h020;
    #1;
    chk("t4_a_grant", 32'(bus.a_grant),  32'(1));
    chk("t4_rd_wren", 32'(bus.mem_wren), 32'(0));
    tick();
    idle();
    chk("t4_a_rvalid", 32'(bus.a_rvalid), 32'(1));
    chk("t4_rdata",    bus.rdata,         32'hDEADBEEF);
    tick();
    chk("t4_a_rvalid_off", 32'(bus.a_rvalid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
